// File: rtl/regbank_arbiter.sv
// Round-robin arbiter guarding a small register bank: one requester at a time
// gets up to BURST_MAX read/write accesses, followed by a one-cycle turnaround.
module regbank_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int AW        = 3,
   parameter int BURST_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   output logic [DW-1:0]      rd_data,
   output logic               rd_valid,
   output logic               busy
);

   localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW    = $clog2(BURST_MAX + 1);
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   last_owner_q, last_owner_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d;
   logic [DW-1:0]   bank_q [DEPTH];
   logic [DW-1:0]   bank_d [DEPTH];

   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   cand_idx;
   int              cand;
   logic [AW-1:0]   acc_addr;
   logic [DW-1:0]   acc_data;

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand     = (int'(last_owner_q) + 1 + k) % NREQ;
         cand_idx = IW'(cand);
         if (!pick_found && req[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_d      = burst_q;
      gnt_d        = gnt_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      bank_d       = bank_q;
      acc_addr     = req_addr[owner_q*AW +: AW];
      acc_data     = req_data[owner_q*DW +: DW];

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d           = GRANT;
               owner_d           = pick_idx;
               burst_d           = '0;
               gnt_d             = '0;
               gnt_d[pick_idx]   = 1'b1;
            end
         end
         GRANT: begin
            if (req[owner_q]) begin
               if (req_we[owner_q]) begin
                  bank_d[acc_addr] = acc_data;
               end else begin
                  rd_data_d  = bank_q[acc_addr];
                  rd_valid_d = 1'b1;
               end
               burst_d = burst_q + BW'(1);
            end
            // A dropped request or an exhausted burst both hand the bank back.
            if (!req[owner_q] || (burst_q == BW'(BURST_MAX - 1))) begin
               state_d      = TURN;
               gnt_d        = '0;
               last_owner_d = owner_q;
               burst_d      = '0;
            end
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= IW'(NREQ - 1);
         burst_q      <= '0;
         gnt_q        <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         bank_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_q      <= burst_d;
         gnt_q        <= gnt_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         bank_q       <= bank_d;
      end
   end

   assign gnt      = gnt_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = |gnt_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Randomised scoreboard bench for regbank_arbiter: a transaction-level model
// predicts grant windows and read results, a monitor matches what the DUT shows.
module tb_regbank_arbiter;

   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int AW        = 3;
   localparam int BURST_MAX = 4;

   logic               clk;
   logic               reset;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic [DW-1:0]      rd_data;
   logic               rd_valid;
   logic               busy;

   regbank_arbiter #(
      .NREQ(NREQ), .DW(DW), .AW(AW), .BURST_MAX(BURST_MAX)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
   );

   typedef struct {
      int owner;
      int start;
      int len;
   } grant_ev_t;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } read_ev_t;

   grant_ev_t gq[$];
   grant_ev_t bq[$];
   read_ev_t  rq[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int reset_epoch = 0;

   // Reference model: who holds the bank, how many accesses used, and the bank itself.
   int            m_owner;
   int            m_last;
   int            m_used;
   int            m_start;
   bit            m_turn;
   logic [DW-1:0] m_bank [1<<AW];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic modelReset();
      m_owner = -1;
      m_last  = NREQ - 1;
      m_used  = 0;
      m_start = 0;
      m_turn  = 1'b0;
      for (int i = 0; i < (1 << AW); i++) m_bank[i] = '0;
   endtask

   // Predicts what the coming rising edge does with the current inputs.
   task automatic modelStep();
      int  e;
      bit  done;
      logic [AW-1:0] a;
      grant_ev_t g;
      read_ev_t  r;
      e    = cyc + 1;
      done = 1'b0;
      if (m_turn) begin
         m_turn = 1'b0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            int c = (m_last + k) % NREQ;
            if (m_owner < 0 && req[c]) m_owner = c;
         end
         if (m_owner >= 0) begin
            m_start = e;
            m_used  = 0;
         end
      end else begin
         if (req[m_owner]) begin
            a = req_addr[m_owner*AW +: AW];
            if (req_we[m_owner]) begin
               m_bank[a] = req_data[m_owner*DW +: DW];
            end else begin
               r.data = m_bank[a];
               r.cyc  = e;
               rq.push_back(r);
            end
            m_used++;
            done = (m_used == BURST_MAX);
         end else begin
            done = 1'b1;
         end
         if (done) begin
            g.owner = m_owner;
            g.start = m_start;
            g.len   = e - m_start;
            gq.push_back(g);
            bq.push_back(g);
            m_last  = m_owner;
            m_owner = -1;
            m_turn  = 1'b1;
         end
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                                input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
      req      = r;
      req_we   = w;
      req_addr = a;
      req_data = d;
      modelStep();
   endtask

   task automatic driveFor(input logic [NREQ-1:0] r, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(r, {NREQ{w}}, {NREQ{a}}, {NREQ{d}});
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: matches each observed grant window, busy window and read pulse to the model.
   int        seen_epoch = 0;
   bit        g_track    = 1'b0;
   logic [NREQ-1:0] g_val;
   int        g_start;
   bit        b_track    = 1'b0;
   int        b_start;

   always @(negedge clk) begin
      grant_ev_t ge;
      read_ev_t  re;
      if (!reset) begin
         if (seen_epoch != reset_epoch) begin
            g_track    = 1'b0;
            b_track    = 1'b0;
            seen_epoch = reset_epoch;
         end
         if (g_track && gnt != g_val) begin
            if (gq.size() == 0) begin
               checkOutput("grant_unexpected", 32'(g_val), 0);
            end else begin
               ge = gq.pop_front();
               checkOutput("grant_owner", 32'(g_val), 32'(1) << ge.owner);
               checkOutput("grant_start", g_start, ge.start);
               checkOutput("grant_len", cyc - g_start, ge.len);
            end
            g_track = 1'b0;
         end
         if (!g_track && gnt != '0) begin
            g_track = 1'b1;
            g_val   = gnt;
            g_start = cyc;
         end
         if (b_track && !busy) begin
            if (bq.size() == 0) begin
               checkOutput("busy_unexpected", 1, 0);
            end else begin
               ge = bq.pop_front();
               checkOutput("busy_start", b_start, ge.start);
               checkOutput("busy_len", cyc - b_start, ge.len);
            end
            b_track = 1'b0;
         end
         if (!b_track && busy) begin
            b_track = 1'b1;
            b_start = cyc;
         end
         if (rd_valid) begin
            if (rq.size() == 0) begin
               checkOutput("rd_valid_unexpected", 1, 0);
            end else begin
               re = rq.pop_front();
               checkOutput("rd_data", 32'(rd_data), 32'(re.data));
               checkOutput("rd_cycle", cyc, re.cyc);
            end
         end
      end
   end

   initial begin
      logic [NREQ-1:0] rbits;
      reset    = 1'b1;
      req      = '0;
      req_we   = '0;
      req_addr = '0;
      req_data = '0;
      modelReset();
      #12;
      checkOutput("reset_gnt", 32'(gnt), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_rd_valid", 32'(rd_valid), 0);
      checkOutput("reset_rd_data", 32'(rd_data), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] first read after reset");
      driveFor(4'b0001, 1'b0, 3'd5, 8'h00, 2);
      driveFor(4'b0000, 1'b0, 3'd0, 8'h00, 3);

      $display("[TB] write then read back");
      driveFor(4'b0100, 1'b1, 3'd3, 8'hA5, 2);
      driveFor(4'b0100, 1'b0, 3'd3, 8'h00, 1);
      driveFor(4'b0000, 1'b0, 3'd0, 8'h00, 4);
      checkOutput("rd_data_hold", 32'(rd_data), 32'h00A5);

      $display("[TB] all requesting");
      driveFor(4'b1111, 1'b0, 3'd3, 8'h00, 40);
      driveFor(4'b0000, 1'b0, 3'd0, 8'h00, 3);

      $display("[TB] long single request");
      driveFor(4'b0010, 1'b1, 3'd1, 8'h3C, 10);
      driveFor(4'b0000, 1'b0, 3'd0, 8'h00, 3);

      $display("[TB] early drop");
      driveFor(4'b1000, 1'b1, 3'd6, 8'h5A, 3);
      driveFor(4'b0000, 1'b0, 3'd0, 8'h00, 2);
      driveFor(4'b1001, 1'b0, 3'd6, 8'h00, 12);
      driveFor(4'b0000, 1'b0, 3'd0, 8'h00, 3);

      $display("[TB] reset during write");
      driveFor(4'b0010, 1'b1, 3'd7, 8'hFF, 1);
      applyStimulus(4'b0010, 4'b1111, {NREQ{3'd7}}, {NREQ{8'hFF}});
      #1 reset = 1'b1;
      #1;
      checkOutput("midreset_gnt", 32'(gnt), 0);
      checkOutput("midreset_busy", 32'(busy), 0);
      checkOutput("midreset_rd_valid", 32'(rd_valid), 0);
      checkOutput("midreset_rd_data", 32'(rd_data), 0);
      #1 reset = 1'b0;
      modelReset();
      gq.delete();
      bq.delete();
      rq.delete();
      reset_epoch++;
      applyStimulus('0, '0, '0, '0);
      @(posedge clk);
      #1;
      driveFor(4'b0001, 1'b0, 3'd7, 8'h00, 3);
      driveFor(4'b0000, 1'b0, 3'd0, 8'h00, 3);

      $display("[TB] random traffic");
      rbits = '0;
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < NREQ; b++) begin
            if ($urandom_range(3) == 0) rbits[b] = ~rbits[b];
         end
         applyStimulus(rbits, NREQ'($urandom), (NREQ*AW)'($urandom), (NREQ*DW)'($urandom));
         @(posedge clk);
         #1;
      end
      driveFor(4'b0000, 1'b0, 3'd0, 8'h00, 8);

      checkOutput("leftover_grants", gq.size(), 0);
      checkOutput("leftover_busy", bq.size(), 0);
      checkOutput("leftover_reads", rq.size(), 0);
      checkOutput("open_grant", 32'(g_track), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
